// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data SRAM port arbiter.
// Address width, starvation limit default and the access-type encoding.
package mem_arb_pkg;

  localparam int ADDR_W         = 14;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    DM_RD = 2'd2,
    DM_WR = 2'd3
  } last_op_e;

  function automatic last_op_e dm_op(input logic [3:0] we);
    return (we == 4'b0000) ? DM_RD : DM_WR;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data memory.
// DM has priority; IF wins once it has waited STARVE_MAX DM grants.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
  parameter int STARVE_MAX = mem_arb_pkg::STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  last_op_e         last_op;
  last_op_e         last_op_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nx;
  logic             starved;
  logic             if_win;
  logic             dm_win;

  assign starved = (starve_cnt == CNT_MAX);

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (rst) begin
      if_win = if_req && (!dm_req || starved);
      dm_win = dm_req && !if_win;
    end
  end

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;

  // SRAM drive for the granted access, quiet bus otherwise.
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'hF;
    sram_a   = '0;
    sram_di  = '0;
    unique case (1'b1)
      if_win: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = if_addr;
      end
      dm_win: begin
        sram_cs  = 1'b1;
        sram_oe  = (dm_we == 4'b0000);
        sram_web = ~dm_we;
        sram_a   = dm_addr;
        sram_di  = dm_wdata;
      end
      default: ;
    endcase
  end

  // Next access type and starvation count.
  always_comb begin
    last_op_nx = IDLE;
    starve_nx  = starve_cnt;
    if (if_win) begin
      last_op_nx = IF_RD;
    end else if (dm_win) begin
      last_op_nx = dm_op(dm_we);
    end
    if (!if_req || if_win) begin
      starve_nx = '0;
    end else if (dm_win && !starved) begin
      starve_nx = starve_cnt + 1'b1;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_op    <= IDLE;
      starve_cnt <= '0;
    end else begin
      last_op    <= last_op_nx;
      starve_cnt <= starve_nx;
    end
  end

  // Route the SRAM read data to whoever issued last cycle's read.
  always_comb begin
    if_rvalid = (last_op == IF_RD);
    dm_rvalid = (last_op == DM_RD);
    if_rdata  = if_rvalid ? sram_do : 32'h0;
    dm_rdata  = dm_rvalid ? sram_do : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-write SRAM.
// Inputs change 1ns after the rising edge; outputs are sampled before the next one.
module tb_mem_port_arbiter;

  localparam int AW = 14;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic [3:0]    dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          sram_cs;
  logic          sram_oe;
  logic [3:0]    sram_web;
  logic [AW-1:0] sram_a;
  logic [31:0]   sram_di;
  logic [31:0]   sram_do;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [31:0]   mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .sram_cs   (sram_cs),
    .sram_oe   (sram_oe),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_di   (sram_di),
    .sram_do   (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (sram_cs) begin
      if (sram_oe) sram_do <= mem[sram_a];
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input string tag);
    chk({tag, "_cs"}, 32'(sram_cs), 32'h0);
    chk({tag, "_oe"}, 32'(sram_oe), 32'h0);
    chk({tag, "_web"}, 32'(sram_web), 32'hF);
    chk({tag, "_a"}, 32'(sram_a), 32'h0);
    chk({tag, "_di"}, sram_di, 32'h0);
  endtask

  logic [9:0] exp_if;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 4'h0; dm_addr = '0; dm_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    sram_do = '0;

    // preload while reset holds the arbiter quiet
    tick();
    ld_en = 1'b1; ld_addr = 14'h0010; ld_data = 32'h0050_0093;
    tick();
    ld_addr = 14'h2000; ld_data = 32'h1122_3344;
    tick();
    ld_en = 1'b0;

    // reset holds everything off even with requests present
    if_req = 1'b1; dm_req = 1'b1;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    idle_bus("rst");
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    rst = 1'b1;
    tick();

    // single fetch, requester drops req right after grant
    if_req = 1'b1; if_addr = 14'h0010;
    #2;
    chk("f_if_gnt", 32'(if_gnt), 32'h1);
    chk("f_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("f_cs", 32'(sram_cs), 32'h1);
    chk("f_oe", 32'(sram_oe), 32'h1);
    chk("f_web", 32'(sram_web), 32'hF);
    chk("f_a", 32'(sram_a), 32'h10);
    tick();
    if_req = 1'b0;
    #1;
    chk("f_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_dm_rvalid", 32'(dm_rvalid), 32'h0);
    idle_bus("f_idle");
    tick();
    chk("f_rvalid_off", 32'(if_rvalid), 32'h0);
    chk("f_rdata_off", if_rdata, 32'h0);

    // partial byte write
    dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 14'h2000;
    dm_wdata = 32'hAABB_CCDD;
    #2;
    chk("w_dm_gnt", 32'(dm_gnt), 32'h1);
    chk("w_cs", 32'(sram_cs), 32'h1);
    chk("w_oe", 32'(sram_oe), 32'h0);
    chk("w_web", 32'(sram_web), 32'hC);
    chk("w_a", 32'(sram_a), 32'h2000);
    chk("w_di", sram_di, 32'hAABB_CCDD);
    tick();
    dm_we = 4'b0000; dm_wdata = '0;
    chk("w_mem", mem[14'h2000], 32'h1122_CCDD);
    chk("w_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("w_if_rvalid", 32'(if_rvalid), 32'h0);
    #2;
    chk("r_oe", 32'(sram_oe), 32'h1);
    chk("r_web", 32'(sram_web), 32'hF);
    tick();
    dm_req = 1'b0;
    chk("r_dm_rvalid", 32'(dm_rvalid), 32'h1);
    chk("r_dm_rdata", dm_rdata, 32'h1122_CCDD);
    tick();

    // contention: four DM reads then one fetch, repeating
    exp_if = 10'b10_0001_0000;
    if_req = 1'b1; if_addr = 14'h0010;
    dm_req = 1'b1; dm_we = 4'b0000; dm_addr = 14'h2000;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("s%0d_if_gnt", i), 32'(if_gnt), 32'(exp_if[i]));
      chk($sformatf("s%0d_dm_gnt", i), 32'(dm_gnt), 32'(!exp_if[i]));
      tick();
      chk($sformatf("s%0d_if_rv", i), 32'(if_rvalid), 32'(exp_if[i]));
      chk($sformatf("s%0d_dm_rv", i), 32'(dm_rvalid), 32'(!exp_if[i]));
      if (exp_if[i])
        chk($sformatf("s%0d_if_rd", i), if_rdata, 32'h0050_0093);
      else
        chk($sformatf("s%0d_dm_rd", i), dm_rdata, 32'h1122_CCDD);
    end

    // alternating single requests, one per cycle, no bubbles
    for (int i = 0; i < 6; i++) begin
      if_req = (i % 2 == 0);
      dm_req = (i % 2 == 1);
      #2;
      chk($sformatf("a%0d_if_gnt", i), 32'(if_gnt), 32'(i % 2 == 0));
      chk($sformatf("a%0d_dm_gnt", i), 32'(dm_gnt), 32'(i % 2 == 1));
      tick();
      chk($sformatf("a%0d_if_rv", i), 32'(if_rvalid), 32'(i % 2 == 0));
      chk($sformatf("a%0d_dm_rv", i), 32'(dm_rvalid), 32'(i % 2 == 1));
      chk($sformatf("a%0d_if_rd", i), if_rdata,
          (i % 2 == 0) ? 32'h0050_0093 : 32'h0);
      chk($sformatf("a%0d_dm_rd", i), dm_rdata,
          (i % 2 == 1) ? 32'h1122_CCDD : 32'h0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // reset right after a DM read grant drops the response
    dm_req = 1'b1; dm_we = 4'b0000; dm_addr = 14'h2000;
    #2;
    chk("x_dm_gnt", 32'(dm_gnt), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("x_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("x_dm_rdata", dm_rdata, 32'h0);
    chk("x_dm_gnt_rst", 32'(dm_gnt), 32'h0);
    idle_bus("x_rst");
    tick();
    chk("x_dm_rvalid2", 32'(dm_rvalid), 32'h0);
    chk("x_if_rvalid2", 32'(if_rvalid), 32'h0);
    dm_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("x_dm_rvalid3", 32'(dm_rvalid), 32'h0);
    idle_bus("x_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
